// File: rtl/demux64_1to2_pkg.sv
// Shared parameters and select encodings for the 1-to-2 result demultiplexer.
package demux64_1to2_pkg;

  localparam int WIDTH_DEFAULT = 64;
  localparam int DEPTH_DEFAULT = 2;

  // Occupancy spans 0..DEPTH, pointers index DEPTH entries.
  localparam int CNT_W = 2;
  localparam int PTR_W = 1;

  typedef enum logic {
    SEL_OUT0 = 1'b0,
    SEL_OUT1 = 1'b1
  } sel_e;

endpackage

// File: rtl/demux64_1to2_fifo2_buf.sv
// Two-entry FIFO buffer: plain push/pop storage, no steering knowledge.
module fifo2_buf
  import demux64_1to2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // A pop on an empty buffer is ignored; a push into a full buffer is only
  // legal when the head leaves in the same cycle.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != FULL_CNT) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= push_data;
  end

  assign data  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;

endmodule

// File: rtl/demux64_1to2.sv
// Steers each accepted input word into one of two independent FIFO buffers.
module demux64_1to2
  import demux64_1to2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             busy
);

  sel_e             sel;
  logic [1:0]       push_en;
  logic [1:0]       pop_en;
  logic [1:0]       buf_full;
  logic [1:0]       buf_valid;
  logic [1:0]       buf_busy;
  logic [1:0]       out_ready;
  logic [WIDTH-1:0] buf_data [2];
  logic [CNT_W-1:0] buf_count [2];

  assign sel       = sel_e'(in_sel);
  assign out_ready = {out1_ready, out0_ready};

  // A full buffer still accepts when its head is consumed this cycle; since a
  // full buffer is always valid, outN_ready alone indicates that pop.
  always_comb begin
    in_ready = 1'b1;
    case (sel)
      SEL_OUT0: in_ready = !buf_full[0] || out0_ready;
      SEL_OUT1: in_ready = !buf_full[1] || out1_ready;
      default:  in_ready = 1'b1;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      assign push_en[gi]  = in_valid && in_ready && (sel == sel_e'(gi)) && !rst;
      assign pop_en[gi]   = out_ready[gi] && !rst;
      assign buf_busy[gi] = (buf_count[gi] != '0);

      fifo2_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push_en[gi]),
        .pop       (pop_en[gi]),
        .push_data (in_data),
        .data      (buf_data[gi]),
        .valid     (buf_valid[gi]),
        .full      (buf_full[gi]),
        .count     (buf_count[gi])
      );
    end
  endgenerate

  assign out0_data  = buf_data[0];
  assign out1_data  = buf_data[1];
  assign out0_valid = buf_valid[0];
  assign out1_valid = buf_valid[1];
  assign busy       = |buf_busy;

endmodule

// File: tb/tb_demux64_1to2.sv
// Scoreboard bench: a stimulus process drives the DUT while a negedge monitor
// checks every transfer and flag against per-output expected-word queues.
module tb_demux64_1to2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out0_data, out1_data;
  logic        out0_valid, out1_valid;
  logic        out0_ready = 1'b0;
  logic        out1_ready = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  demux64_1to2 dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: inputs change 1 time unit after posedge, so at the
  // negedge every handshake about to happen on the next edge is stable.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      chk("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
      chk("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
      chk("busy", 64'(busy), 64'((q0.size() != 0) || (q1.size() != 0)));
      chk("in_ready", 64'(in_ready),
          64'(in_sel ? ((q1.size() < 2) || out1_ready) : ((q0.size() < 2) || out0_ready)));
      if (out0_valid && out0_ready && q0.size() != 0) chk("out0_data", out0_data, q0.pop_front());
      if (out1_valid && out1_ready && q1.size() != 0) chk("out1_data", out1_data, q1.pop_front());
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic [63:0] d,
                       input logic r0, input logic r1, output logic rdy);
    in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    rdy = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic rdy;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, rdy);
  endtask

  initial begin
    logic rdy;
    int   n_acc;

    rst = 1'b1;
    drive(1'b1, 1'b0, 64'h1234, 1'b1, 1'b1, rdy);
    drive(1'b1, 1'b1, 64'h5678, 1'b1, 1'b1, rdy);
    rst = 1'b0;
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, rdy);
    chk("reset out0_valid", 64'(out0_valid), 64'd0);
    chk("reset out1_valid", 64'(out1_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset in_ready", 64'(rdy), 64'd1);

    // Single word to output 0, visible the following cycle.
    drive(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, rdy);
    chk("first out0_valid", 64'(out0_valid), 64'd1);
    chk("first out0_data", out0_data, 64'hDEAD_BEEF_0000_0001);
    chk("first out1_valid", 64'(out1_valid), 64'd0);
    chk("first busy", 64'(busy), 64'd1);
    drain();

    // Output 1 fills at two words; the third enters as the first leaves.
    drive(1'b1, 1'b1, 64'd1, 1'b0, 1'b0, rdy);  chk("w1 ready", 64'(rdy), 64'd1);
    drive(1'b1, 1'b1, 64'd2, 1'b0, 1'b0, rdy);  chk("w2 ready", 64'(rdy), 64'd1);
    drive(1'b1, 1'b1, 64'd3, 1'b0, 1'b0, rdy);  chk("w3 blocked", 64'(rdy), 64'd0);
    chk("full out1_data", out1_data, 64'd1);
    drive(1'b1, 1'b1, 64'd3, 1'b0, 1'b1, rdy);  chk("w3 with pop", 64'(rdy), 64'd1);
    chk("after pop out1_data", out1_data, 64'd2);

    // Stalled full output 1 does not block output 0.
    drive(1'b1, 1'b0, 64'hA5, 1'b0, 1'b0, rdy); chk("A5 ready", 64'(rdy), 64'd1);
    chk("A5 out0_data", out0_data, 64'hA5);
    chk("A5 out1 held", out1_data, 64'd2);
    drain();

    // Push and pop on a full buffer keeps occupancy at two.
    drive(1'b1, 1'b0, 64'h11, 1'b0, 1'b0, rdy);
    drive(1'b1, 1'b0, 64'h22, 1'b0, 1'b0, rdy);
    drive(1'b1, 1'b0, 64'h77, 1'b1, 1'b0, rdy); chk("77 ready", 64'(rdy), 64'd1);
    chk("77 head", out0_data, 64'h22);
    drive(1'b1, 1'b0, 64'h99, 1'b0, 1'b0, rdy); chk("still full", 64'(rdy), 64'd0);
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 64'h1000 + 64'(i), 1'b1, 1'b0, rdy);
      if (rdy) n_acc++;
    end
    chk("stream accepted", 64'(n_acc), 64'd20);
    drain();

    // Reset with both buffers full discards everything.
    drive(1'b1, 1'b0, 64'hAAAA, 1'b0, 1'b0, rdy);
    drive(1'b1, 1'b0, 64'hBBBB, 1'b0, 1'b0, rdy);
    drive(1'b1, 1'b1, 64'hCCCC, 1'b0, 1'b0, rdy);
    drive(1'b1, 1'b1, 64'hDDDD, 1'b0, 1'b0, rdy);
    rst = 1'b1;
    drive(1'b1, 1'b0, 64'hEEEE, 1'b1, 1'b1, rdy);
    rst = 1'b0;
    chk("rst out0_valid", 64'(out0_valid), 64'd0);
    chk("rst out1_valid", 64'(out1_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, rdy);
    chk("rst in_ready", 64'(rdy), 64'd1);
    drain();

    // Random traffic, checked cycle by cycle by the monitor.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            {$urandom, $urandom},
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0), rdy);
    end
    drain();
    chk("final busy", 64'(busy), 64'd0);
    chk("final q0 empty", 64'(q0.size()), 64'd0);
    chk("final q1 empty", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux64_1to2.md
DEMUX64_1TO2 -- requirements
Module: demux64_1to2

Interface
REQ-001 Parameter WIDTH, default 64, data path width in bits.
REQ-002 Parameter DEPTH, default 2, entries per output buffer; fixed at 2 for this release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  WIDTH  result word to steer.
REQ-006 in_sel  input  1  destination select: 0 -> output 0, 1 -> output 1.
REQ-007 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 in_ready  output  1  block accepts the input word this cycle.
REQ-009 out0_data  output  WIDTH  head word of buffer 0.
REQ-010 out0_valid  output  1  buffer 0 non-empty.
REQ-011 out0_ready  input  1  consumer 0 takes head word.
REQ-012 out1_data / out1_valid / out1_ready: same as REQ-009..011 for buffer 1.
REQ-013 busy  output  1  either buffer non-empty.

Function
REQ-014 Transfer in: in_valid && in_ready at a rising edge; the word is written into the buffer selected by in_sel.
REQ-015 Transfer out: outN_valid && outN_ready at a rising edge; head of buffer N is removed.
REQ-016 in_ready = 1 when the selected buffer holds fewer than DEPTH entries, or holds DEPTH entries and is popped in the same cycle.
REQ-017 in_ready depends combinationally on in_sel and outN_ready only; never on in_valid.
REQ-018 Latency: an accepted word appears on outN_data with outN_valid=1 in the next cycle; no same-cycle bypass.
REQ-019 Each buffer is FIFO; words to the same output leave in acceptance order.
REQ-020 The buffers are independent; a stalled output never blocks traffic to the other output.
REQ-021 Simultaneous push and pop on one buffer leaves the occupancy unchanged and is legal at any occupancy, including empty->push is not a pop.
REQ-022 Empty buffer: a pop request is ignored (outN_valid=0), and outN_data is don't-care.
REQ-023 Read/write pointers are 1 bit and wrap modulo DEPTH; occupancy counter range 0..DEPTH, never exceeds DEPTH.
REQ-024 outN_data and outN_valid are stable while outN_valid=1 and outN_ready=0.
REQ-025 busy = out0_valid | out1_valid.
REQ-026 in_data is not modified or truncated; full WIDTH bits are delivered.

Reset
REQ-027 While rst=1 at a rising edge, both occupancies and all pointers clear to 0.
REQ-028 Reset values: out0_valid=0, out1_valid=0, busy=0; in_ready=1 in the first cycle after reset release.
REQ-029 Reset mid-operation discards all buffered words; no word accepted before reset is ever presented after it.
REQ-030 While rst=1, inputs are ignored and no transfer in or out takes place.
REQ-031 Data storage registers need no reset.

Structure
REQ-032 A shared package holds WIDTH default (64), DEPTH default (2), and the select encodings SEL_OUT0=0, SEL_OUT1=1.
REQ-033 One sub-module, fifo2_buf, is instantiated twice (one per output) and provides push, pop, data, valid, full and count.
REQ-034 Steering logic (push-enable decode and in_ready) is in demux64_1to2; no steering logic is in fifo2_buf.

Verification
REQ-035 After reset, drive in_data=64'hDEAD_BEEF_0000_0001, in_sel=0, in_valid=1 for one cycle, with out0_ready=0 -> next cycle out0_valid=1, out0_data=64'hDEAD_BEEF_0000_0001, out1_valid=0, busy=1.
REQ-036 With out1_ready=0, send 3 words 1,2,3 with in_sel=1 -> words 1 and 2 are accepted and in_ready=0 for word 3. With out1_ready=1, the outputs are 1 then 2, and word 3 is accepted in the cycle that 1 pops.
REQ-037 Hold out1 full with out1_ready=0 and send 0xA5 with in_sel=0 -> in_ready=1, 0xA5 appears on out0 next cycle.
REQ-038 Buffer 0 holds 2 words, out0_ready=1, in_valid=1, in_sel=0, data 0x77 -> accepted the same cycle, occupancy stays 2, order preserved; 20 back-to-back words stream 1 per cycle without loss.
REQ-039 Fill both buffers, assert rst for 1 cycle -> out0_valid=out1_valid=busy=0, in_ready=1, and no pre-reset word is emitted afterwards.
REQ-040 Random in_sel/in_valid/outN_ready for 10k cycles against a scoreboard -> no loss, no duplication, per-output order preserved.
